fm_window_3x3: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution stage. It accepts a raster-order feature-map pixel stream and buffers two full lines. Every cycle a full 3x3 neighbourhood is available, it presents the nine 16-bit samples as one packed 144-bit word, with the `matrix_*` video control signals and window counters the convolution stage consumes. Padding is "valid" (no border padding): a FM_WIDTH x FM_HEIGHT input produces (FM_WIDTH-2) x (FM_HEIGHT-2) windows.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/fm_line_buf.sv | 27 ++
 rtl/fm_window_3x3.sv | 141 ++++++++++++++
 tb/tb_fm_window_3x3.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN packing constants: window geometry and the slice position of
// each window element inside the packed word, so the window generator and
// the convolution stage agree on layout.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int WIN_K  = 3;
  localparam int WIN_N  = WIN_K * WIN_K;
  localparam int WIN_W  = WIN_N * DATA_W;

  // Bit offsets of element (r,c); (r0,c0) sits in the top slice.
  localparam int OFF_R0C0 = 8 * DATA_W;
  localparam int OFF_R0C1 = 7 * DATA_W;
  localparam int OFF_R0C2 = 6 * DATA_W;
  localparam int OFF_R1C0 = 5 * DATA_W;
  localparam int OFF_R1C1 = 4 * DATA_W;
  localparam int OFF_R1C2 = 3 * DATA_W;
  localparam int OFF_R2C0 = 2 * DATA_W;
  localparam int OFF_R2C1 = 1 * DATA_W;
  localparam int OFF_R2C2 = 0;

  // Slot index of element (r,c); multiply by the sample width for the offset.
  function automatic int win_elem(input int r, input int c);
    return (WIN_N - 1) - (WIN_K * r + c);
  endfunction

endpackage

// File: rtl/fm_line_buf.sv
// Single-port line buffer, one line deep, read-before-write: the read port
// returns the sample stored one line earlier at the same column while the
// new sample overwrites it on the same clock.
module fm_line_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  // Store the accepted sample; the old value has already been read out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/fm_window_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window
// turn a raster pixel stream into one packed neighbourhood per valid
// ("valid" padding) position, one cycle after the pixel completing it.
module fm_window_3x3 #(
  parameter int FM_WIDTH  = 8,
  parameter int FM_HEIGHT = 8,
  parameter int DATA_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fm_vsync,
  input  logic                fm_href,
  input  logic [DATA_W-1:0]   fm_pixel,
  output logic                matrix_vsync,
  output logic                matrix_href,
  output logic [6:0]          matrix_h_cnt,
  output logic [6:0]          matrix_v_cnt,
  output logic [9*DATA_W-1:0] fm_data
);
  import cnn_pkg::*;

  localparam int         LB_AW  = $clog2(FM_WIDTH);
  localparam logic [6:0] H_LAST = 7'(FM_WIDTH - 1);
  localparam logic [6:0] V_LAST = 7'(FM_HEIGHT - 1);

  logic                vsync_prev_q, vsync_prev_d;
  logic                sampled_q, sampled_d;
  logic                active_q, active_d;
  logic [6:0]          in_h_q, in_h_d, in_v_q, in_v_d;
  logic [6:0]          h_cur, v_cur;
  logic                frame_start, run, win_valid;
  logic [DATA_W-1:0]   win_q [WIN_K][WIN_K];
  logic [DATA_W-1:0]   win_d [WIN_K][WIN_K];
  logic [DATA_W-1:0]   lb1_out, lb2_out;
  logic [9*DATA_W-1:0] win_flat;
  logic                href_q, href_d;
  logic [6:0]          h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9*DATA_W-1:0] fm_data_q, fm_data_d;

  // LB1 yields row-1 and stores the new pixel; LB2 yields row-2 and stores row-1.
  fm_line_buf #(.DEPTH(FM_WIDTH), .DATA_W(DATA_W)) u_lb1 (
    .clk     (clk),
    .wr_en   (fm_href),
    .addr    (h_cur[LB_AW-1:0]),
    .wr_data (fm_pixel),
    .rd_data (lb1_out)
  );

  fm_line_buf #(.DEPTH(FM_WIDTH), .DATA_W(DATA_W)) u_lb2 (
    .clk     (clk),
    .wr_en   (fm_href),
    .addr    (h_cur[LB_AW-1:0]),
    .wr_data (lb1_out),
    .rd_data (lb2_out)
  );

  // Frame tracking, raster counters, window shift and output hold logic.
  // sampled_q blocks a false edge in the first cycle after reset when vsync
  // is already high, so a reset mid-frame stays quiet until a real rise.
  always_comb begin
    frame_start  = fm_vsync & ~vsync_prev_q & sampled_q;
    run          = active_q | frame_start;
    h_cur        = frame_start ? 7'd0 : in_h_q;
    v_cur        = frame_start ? 7'd0 : in_v_q;
    win_valid    = fm_href & run & (h_cur >= 7'd2) & (v_cur >= 7'd2);
    vsync_prev_d = fm_vsync;
    sampled_d    = 1'b1;
    active_d     = run;
    in_h_d       = h_cur;
    in_v_d       = v_cur;
    if (fm_href && run) begin
      if (h_cur == H_LAST) begin
        in_h_d = 7'd0;
        in_v_d = (v_cur == V_LAST) ? 7'd0 : v_cur + 7'd1;
      end else begin
        in_h_d = h_cur + 7'd1;
      end
    end

    win_d = win_q;
    if (fm_href) begin
      for (int r = 0; r < WIN_K; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_out;
      win_d[1][2] = lb1_out;
      win_d[2][2] = fm_pixel;
    end

    win_flat = '0;
    for (int r = 0; r < WIN_K; r++) begin
      for (int c = 0; c < WIN_K; c++) begin
        win_flat[win_elem(r, c)*DATA_W +: DATA_W] = win_d[r][c];
      end
    end

    href_d    = win_valid;
    h_cnt_d   = win_valid ? h_cur - 7'd2 : h_cnt_q;
    v_cnt_d   = win_valid ? v_cur - 7'd2 : v_cnt_q;
    fm_data_d = win_valid ? win_flat : fm_data_q;
  end

  // State and output registers; line-buffer contents are left uncleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      sampled_q    <= 1'b0;
      active_q     <= 1'b0;
      in_h_q       <= '0;
      in_v_q       <= '0;
      for (int r = 0; r < WIN_K; r++) begin
        for (int c = 0; c < WIN_K; c++) begin
          win_q[r][c] <= '0;
        end
      end
      href_q       <= 1'b0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      fm_data_q    <= '0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      sampled_q    <= sampled_d;
      active_q     <= active_d;
      in_h_q       <= in_h_d;
      in_v_q       <= in_v_d;
      win_q        <= win_d;
      href_q       <= href_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      fm_data_q    <= fm_data_d;
    end
  end

  assign matrix_vsync = vsync_prev_q;
  assign matrix_href  = href_q;
  assign matrix_h_cnt = h_cnt_q;
  assign matrix_v_cnt = v_cnt_q;
  assign fm_data      = fm_data_q;

endmodule

// File: tb/tb_fm_window_3x3.sv
// Scoreboard bench for fm_window_3x3: the bench keeps its own image of each
// frame, queues the expected window for every pixel that completes one, and
// checks the DUT one cycle later.
`timescale 1ns/1ps
module tb_fm_window_3x3;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 16;

  localparam logic [9*DW-1:0] FIRST_RAMP =
    {16'd0, 16'd1, 16'd2, 16'd8, 16'd9, 16'd10, 16'd16, 16'd17, 16'd18};
  localparam logic [9*DW-1:0] LAST_RAMP =
    {16'd45, 16'd46, 16'd47, 16'd53, 16'd54, 16'd55, 16'd61, 16'd62, 16'd63};
  localparam logic [9*DW-1:0] FIRST_P100 =
    {16'd100, 16'd101, 16'd102, 16'd108, 16'd109, 16'd110, 16'd116, 16'd117, 16'd118};
  localparam logic [9*DW-1:0] FIRST_SIGNED =
    {16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fm_vsync = 1'b0;
  logic          fm_href = 1'b0;
  logic [DW-1:0] fm_pixel = '0;
  logic          matrix_vsync;
  logic          matrix_href;
  logic [6:0]    matrix_h_cnt;
  logic [6:0]    matrix_v_cnt;
  logic [9*DW-1:0] fm_data;

  fm_window_3x3 #(.FM_WIDTH(W), .FM_HEIGHT(H), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fm_vsync     (fm_vsync),
    .fm_href      (fm_href),
    .fm_pixel     (fm_pixel),
    .matrix_vsync (matrix_vsync),
    .matrix_href  (matrix_href),
    .matrix_h_cnt (matrix_h_cnt),
    .matrix_v_cnt (matrix_v_cnt),
    .fm_data      (fm_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9*DW-1:0] data;
    logic [6:0]      h;
    logic [6:0]      v;
  } exp_t;

  exp_t          expQ[$];
  exp_t          lastExp;
  exp_t          firstSeen;
  exp_t          lastSeen;
  logic [DW-1:0] img [H][W];
  int            total = 0;
  int            bad = 0;
  int            pulseCount = 0;

  function automatic logic [DW-1:0] pixVal(input int mode, input int base, input int v, input int h);
    if (mode == 1) return ((8 * v + h) % 2 == 1) ? 16'h7FFF : 16'h8000;
    return 16'(base + 8 * v + h);
  endfunction

  function automatic logic [9*DW-1:0] winOf(input int v, input int h);
    logic [9*DW-1:0] d;
    d = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        d[(8 - (3 * r + c)) * DW +: DW] = img[v - 2 + r][h - 2 + c];
    return d;
  endfunction

  task automatic checkValue(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    logic expHref;
    expHref = (expQ.size() > 0);
    checkValue("href", 144'(matrix_href), 144'(expHref));
    if (matrix_href === 1'b1) begin
      pulseCount++;
      lastSeen = {fm_data, matrix_h_cnt, matrix_v_cnt};
      if (pulseCount == 1) firstSeen = lastSeen;
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      lastExp = e;
    end
    checkValue("fm_data", fm_data, lastExp.data);
    checkValue("h_cnt", 144'(matrix_h_cnt), 144'(lastExp.h));
    checkValue("v_cnt", 144'(matrix_v_cnt), 144'(lastExp.v));
    if (rst_n) checkValue("vsync", 144'(matrix_vsync), 144'(fm_vsync));
  endtask

  task automatic applyStimulus(input logic vs, input logic hr, input logic [DW-1:0] px);
    @(negedge clk);
    fm_vsync = vs;
    fm_href  = hr;
    fm_pixel = px;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic sendFrame(input int mode, input int base, input int gap, input int lead,
                           input int trail, input int count);
    exp_t e;
    int   v;
    int   h;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = pixVal(mode, base, y, x);
    pulseCount = 0;
    for (int i = 0; i < lead; i++) applyStimulus(1'b1, 1'b0, 16'hDEAD);
    for (int i = 0; i < count; i++) begin
      v = i / W;
      h = i % W;
      if (h >= 2 && v >= 2) begin
        e.data = winOf(v, h);
        e.h    = 7'(h - 2);
        e.v    = 7'(v - 2);
        expQ.push_back(e);
      end
      applyStimulus(1'b1, 1'b1, img[v][h]);
      for (int g = 0; g < gap; g++) applyStimulus(1'b1, 1'b0, 16'($urandom));
    end
    for (int i = 0; i < trail; i++) applyStimulus(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic checkResetOutputs();
    checkValue("rst_href", 144'(matrix_href), 144'(0));
    checkValue("rst_vsync", 144'(matrix_vsync), 144'(0));
    checkValue("rst_h_cnt", 144'(matrix_h_cnt), 144'(0));
    checkValue("rst_v_cnt", 144'(matrix_v_cnt), 144'(0));
    checkValue("rst_data", fm_data, '0);
  endtask

  initial begin
    lastExp = '0;
    firstSeen = '0;
    lastSeen = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000);

    $display("[TB] ramp frame, continuous href, vsync rise with first pixel");
    sendFrame(0, 0, 0, 0, 2, 64);
    checkValue("s1_pulses", 144'(pulseCount), 144'(36));
    checkValue("s1_first", firstSeen.data, FIRST_RAMP);
    checkValue("s1_first_pos", 144'({firstSeen.h, firstSeen.v}), 144'(0));
    checkValue("s1_last", lastSeen.data, LAST_RAMP);
    checkValue("s1_last_pos", 144'({lastSeen.h, lastSeen.v}), 144'({7'd5, 7'd5}));

    $display("[TB] ramp frame, href gaps, vsync leading");
    sendFrame(0, 0, 1, 2, 2, 64);
    checkValue("s2_pulses", 144'(pulseCount), 144'(36));
    checkValue("s2_first", firstSeen.data, FIRST_RAMP);
    checkValue("s2_last", lastSeen.data, LAST_RAMP);

    $display("[TB] signed extremes frame");
    sendFrame(1, 0, 0, 1, 2, 64);
    checkValue("s3_pulses", 144'(pulseCount), 144'(36));
    checkValue("s3_first", firstSeen.data, FIRST_SIGNED);

    $display("[TB] back-to-back frames");
    sendFrame(0, 0, 0, 1, 1, 64);
    checkValue("s4a_pulses", 144'(pulseCount), 144'(36));
    sendFrame(0, 100, 0, 0, 2, 64);
    checkValue("s4b_pulses", 144'(pulseCount), 144'(36));
    checkValue("s4b_first", firstSeen.data, FIRST_P100);

    $display("[TB] reset at pixel (4,3), then a fresh frame");
    sendFrame(0, 0, 0, 0, 0, 29);
    checkValue("s5_partial_pulses", 144'(pulseCount), 144'(9));
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs();
    expQ.delete();
    lastExp = '0;
    repeat (2) applyStimulus(1'b1, 1'b1, 16'h1234);
    @(negedge clk);
    rst_n = 1'b1;
    pulseCount = 0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 16'(i + 40));
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkValue("s5_quiet", 144'(pulseCount), 144'(0));
    sendFrame(0, 0, 0, 0, 2, 64);
    checkValue("s5_pulses", 144'(pulseCount), 144'(36));
    checkValue("s5_first", firstSeen.data, FIRST_RAMP);
    checkValue("s5_last", lastSeen.data, LAST_RAMP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
